addsub_ex_stage: RTL and testbench

//  Execute-stage wrapper for the 16-bit saturating add/sub datapath (Adder_16bit, instantiated inside).
//  - Accepts ADD/SUB requests over a valid/ready handshake and drives the adder.
//  - Registers the saturated result and overflow into a one-entry output stage.
//  - Maintains the architectural Z/V/N flag register.
//  - Sits between decode/operand fetch (upstream) and writeback (downstream).

---
 rtl/addsub_ex_stage.sv | 113 +++++++++++
 tb/tb_addsub_ex_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_ex_stage.sv
// rtl/addsub_ex_stage.sv - Add/sub execute stage with saturating adder, 1-entry output reg, Z/V/N flags; optional SAT_CNT_EN counter.

module Adder_16bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_ovfl
);
    logic [15:0] w_raw;

    assign w_raw  = i_a + i_b + {15'd0, i_cin};
    assign o_ovfl = (i_a[15] == i_b[15]) && (w_raw[15] != i_a[15]);
    // A raw sign bit of 1 after overflow means the true result was too positive.
    assign o_sum  = o_ovfl ? (w_raw[15] ? 16'h7FFF : 16'h8000) : w_raw;
endmodule

module addsub_ex_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_sub,
    input  logic             in_flags_we,
    input  logic             in_nowb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             out_ovfl,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic [CNT_W-1:0] sat_count
);
    logic        r_out_valid;
    logic [15:0] r_out_result;
    logic        r_out_ovfl;
    logic        r_flag_z;
    logic        r_flag_v;
    logic        r_flag_n;
    logic [15:0] w_b_inv;
    logic [15:0] w_sat;
    logic        w_ovfl;
    logic        w_accept;

    assign w_b_inv  = in_sub ? ~in_b : in_b;
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    Adder_16bit u_adder (
        .i_a    (in_a),
        .i_b    (w_b_inv),
        .i_cin  (in_sub),
        .o_sum  (w_sat),
        .o_ovfl (w_ovfl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= 16'h0000;
            r_out_ovfl   <= 1'b0;
        end else if (w_accept && !in_nowb) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_sat;
            r_out_ovfl   <= w_ovfl;
        end else if (w_accept) begin
            // Compare-only: held entry survives only if it is not being consumed.
            r_out_valid  <= r_out_valid & ~out_ready;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_accept && in_flags_we) begin
            r_flag_z <= (w_sat == 16'h0000);
            r_flag_v <= w_ovfl;
            r_flag_n <= w_sat[15];
        end
    end

`ifdef SAT_CNT_EN
    logic [CNT_W-1:0] r_sat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (w_accept && w_ovfl && (r_sat_count != {CNT_W{1'b1}})) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

    assign sat_count = r_sat_count;
`else
    assign sat_count = '0;
`endif

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_ovfl   = r_out_ovfl;
    assign flag_z     = r_flag_z;
    assign flag_v     = r_flag_v;
    assign flag_n     = r_flag_n;
endmodule

// File: tb/tb_addsub_ex_stage.sv
// tb/tb_addsub_ex_stage.sv - Randomized self-checking bench for addsub_ex_stage against a behavioural model.

module tb_addsub_ex_stage;
`ifdef SAT_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_sub, in_flags_we, in_nowb;
    logic [15:0]   in_a, in_b;
    logic          out_valid, out_ready, out_ovfl;
    logic [15:0]   out_result;
    logic          flag_z, flag_v, flag_n;
    logic [CW-1:0] sat_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // model state
    bit          m_valid, m_ovfl, m_z, m_v, m_n, m_pending;
    logic [15:0] m_result;
    int          m_cnt;

    always #5 clk = ~clk;

    addsub_ex_stage #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .in_flags_we(in_flags_we), .in_nowb(in_nowb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_ovfl(out_ovfl),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
        .sat_count(sat_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact signed arithmetic, then clamp to the 16-bit signed range.
    task automatic sat_op(input logic [15:0] a, input logic [15:0] b, input bit sub,
                          output logic [15:0] res, output bit ovf);
        int ex;
        ex = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        ovf = (ex > 32767) || (ex < -32768);
        if (ex > 32767)       res = 16'h7FFF;
        else if (ex < -32768) res = 16'h8000;
        else                  res = ex[15:0];
    endtask

    always @(posedge clk) begin
        logic [15:0] r;
        bit          o, acc;
        if (rst) begin
            m_valid = 0; m_result = 0; m_ovfl = 0;
            m_z = 0; m_v = 0; m_n = 0; m_cnt = 0; m_pending = 0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            sat_op(in_a, in_b, in_sub, r, o);
            m_pending = in_valid && !acc;
            if (acc) begin
                if (in_flags_we) begin
                    m_z = (r == 16'h0000); m_v = o; m_n = r[15];
                end
`ifdef SAT_CNT_EN
                if (o && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
                if (!in_nowb) begin
                    m_valid = 1; m_result = r; m_ovfl = o;
                end else begin
                    m_valid = m_valid && !out_ready;
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("out_result", 32'(out_result), 32'(m_result));
            chk("out_ovfl", 32'(out_ovfl), 32'(m_ovfl));
            chk("flag_z", 32'(flag_z), 32'(m_z));
            chk("flag_v", 32'(flag_v), 32'(m_v));
            chk("flag_n", 32'(flag_n), 32'(m_n));
            chk("sat_count", 32'(sat_count), 32'(m_cnt));
        end
    end

    task automatic apply(input bit v, input logic [15:0] a, input logic [15:0] b, input bit sub,
                         input bit fwe, input bit nowb, input bit ordy, input bit r);
        @(negedge clk);
        #1;
        in_valid = v; in_a = a; in_b = b; in_sub = sub;
        in_flags_we = fwe; in_nowb = nowb; out_ready = ordy; rst = r;
    endtask

    task automatic idle(input bit ordy);
        apply(0, 16'h0, 16'h0, 0, 0, 0, ordy, 0);
        #3;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_sub = 0;
        in_flags_we = 0; in_nowb = 0; out_ready = 0;
        @(negedge clk); @(negedge clk);
        chk_en = 1;
        idle(0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_result", 32'(out_result), 0);
        chk("rst in_ready", 32'(in_ready), 1);

        // saturating add and sub
        apply(1, 16'h7FFF, 16'h0001, 0, 1, 0, 1, 0); idle(1);
        chk("t1 result", 32'(out_result), 32'h7FFF);
        chk("t1 ovfl", 32'(out_ovfl), 1);
        chk("t1 vnz", {29'd0, flag_v, flag_n, flag_z}, 32'b100);
        apply(1, 16'h8000, 16'h0001, 1, 1, 0, 1, 0); idle(1);
        chk("t2a result", 32'(out_result), 32'h8000);
        chk("t2a vnz", {29'd0, flag_v, flag_n, flag_z}, 32'b110);
        apply(1, 16'h0005, 16'h0005, 1, 1, 0, 1, 0); idle(1);
        chk("t2b result", 32'(out_result), 32'h0000);
        chk("t2b vnz", {29'd0, flag_v, flag_n, flag_z}, 32'b001);

        // back-to-back
        apply(1, 16'd1, 16'd2, 0, 0, 0, 1, 0);
        apply(1, 16'd3, 16'd4, 0, 0, 0, 1, 0); #3;
        chk("t4 r0", 32'(out_result), 3);
        apply(1, 16'd5, 16'd6, 0, 0, 0, 1, 0); #3;
        chk("t4 r1", 32'(out_result), 7);
        idle(1);
        chk("t4 r2", 32'(out_result), 11);
        idle(1);

        // compare-only
        apply(1, 16'd3, 16'd3, 1, 1, 1, 1, 0); idle(1);
        chk("t5 valid", 32'(out_valid), 0);
        chk("t5 z", 32'(flag_z), 1);
        chk("t5 held", 32'(out_result), 11);
        apply(1, 16'd1, 16'd1, 0, 1, 1, 1, 0);
        apply(1, 16'd3, 16'd3, 1, 0, 1, 1, 0); #3;
        chk("t5 z clr", 32'(flag_z), 0);
        idle(1);
        chk("t5 z kept", 32'(flag_z), 0);

        // stall then release
        apply(1, 16'd10, 16'd20, 0, 1, 0, 0, 0);
        apply(1, 16'd100, 16'd200, 0, 1, 0, 0, 0); #3;
        chk("t3 in_ready", 32'(in_ready), 0);
        chk("t3 held", 32'(out_result), 30);
        apply(1, 16'd100, 16'd200, 0, 1, 0, 0, 0); #3;
        chk("t3 still", 32'(out_result), 30);
        apply(1, 16'd100, 16'd200, 0, 1, 0, 1, 0); #3;
        chk("t3 ready", 32'(in_ready), 1);
        idle(1);
        chk("t3 valid", 32'(out_valid), 1);
        chk("t3 result", 32'(out_result), 300);

        // reset with in-flight result and request
        apply(1, 16'd1, 16'd1, 0, 1, 0, 0, 0);
        apply(1, 16'h7FFF, 16'h7FFF, 0, 1, 0, 0, 1);
        idle(0);
        chk("t6 valid", 32'(out_valid), 0);
        chk("t6 result", 32'(out_result), 0);
        chk("t6 flags", {29'd0, flag_v, flag_n, flag_z}, 0);
        chk("t6 in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 5; i++) apply(1, 16'h7FFF, 16'h0001, 0, 0, 0, 1, 0);
        idle(1);
`ifdef SAT_CNT_EN
        chk("sat cnt", 32'(sat_count), 3);
`else
        chk("sat cnt", 32'(sat_count), 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            rst = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!m_pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a = pick(); in_b = pick();
                in_sub = 1'($urandom); in_flags_we = 1'($urandom);
                in_nowb = ($urandom_range(0, 4) == 0);
            end
        end
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
